mic_array_frame_sched: RTL

//  Frame scheduler for the microphone array front end. Generates the shared WS
//  for all i2s_decoder instances, collects each decoder's left-channel sample on
//  its recv_over pulse, and at every frame boundary snapshots the set. It then

---
 rtl/mic_array_frame_sched.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mic_array_frame_sched.sv
// Microphone array frame scheduler: shared WS generation, per-channel sample capture,
// and a per-frame snapshot drained as one valid/ready beat per channel.
module mic_array_frame_sched #(
    parameter int NUM_MIC    = 8,
    parameter int DATAWIDTH  = 24,
    parameter int FRAME_BITS = 64,
    parameter int FCNT_W     = 16
) (
    input  logic                           clk_mic,
    input  logic                           rst_mic,
    input  logic                           enable,
    output logic                           ws,
    input  logic [NUM_MIC-1:0]             recv_over,
    input  logic [NUM_MIC*DATAWIDTH-1:0]   mic_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [DATAWIDTH-1:0]    out_data,
    output logic [$clog2(NUM_MIC)-1:0]     out_ch,
    output logic                           out_last,
    output logic                           out_stale,
    output logic [FCNT_W-1:0]              out_frame,
    output logic                           overrun
);

    localparam int CH_W = $clog2(NUM_MIC);
    localparam int BC_W = $clog2(FRAME_BITS);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                      state;
    logic [BC_W-1:0]             bit_cnt;
    logic [BC_W-1:0]             bit_cnt_nxt;
    logic [FCNT_W-1:0]           frame_cnt;
    logic [NUM_MIC-1:0]          pend;
    logic [NUM_MIC-1:0]          mask;
    logic signed [DATAWIDTH-1:0] hold [NUM_MIC];
    logic signed [DATAWIDTH-1:0] snap [NUM_MIC];
    logic [CH_W-1:0]             idx;
    logic [CH_W-1:0]             nidx;
    logic                        boundary;
    logic                        xfer;
    logic                        last_xfer;
    logic                        take;

    always_comb begin
        boundary    = enable && (bit_cnt == BC_W'(FRAME_BITS - 1));
        bit_cnt_nxt = (enable && !boundary) ? bit_cnt + 1'b1 : '0;
        xfer        = out_valid && out_ready;
        last_xfer   = xfer && (idx == CH_W'(NUM_MIC - 1));
        // A boundary coinciding with the final handshake starts the next drain at once.
        take        = boundary && ((state == IDLE) || last_xfer);
        nidx        = idx + 1'b1;
    end

    always_ff @(posedge clk_mic) begin
        if (rst_mic) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            ws        <= 1'b0;
            frame_cnt <= '0;
            pend      <= '0;
            mask      <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
            out_stale <= 1'b0;
            out_frame <= '0;
            overrun   <= 1'b0;
            for (int i = 0; i < NUM_MIC; i++) begin
                hold[i] <= '0;
                snap[i] <= '0;
            end
        end else begin
            bit_cnt <= bit_cnt_nxt;
            ws      <= (bit_cnt_nxt >= BC_W'(FRAME_BITS / 2));

            for (int i = 0; i < NUM_MIC; i++) begin
                if (recv_over[i])
                    hold[i] <= mic_data[i*DATAWIDTH +: DATAWIDTH];
            end

            // Pulses on the boundary cycle belong to the following frame.
            if (!enable)
                pend <= '0;
            else if (boundary)
                pend <= recv_over;
            else
                pend <= pend | recv_over;

            if (boundary)
                frame_cnt <= frame_cnt + 1'b1;
            if (boundary && !take)
                overrun <= 1'b1;

            if (take) begin
                snap      <= hold;
                mask      <= pend;
                out_frame <= frame_cnt;
                idx       <= '0;
                state     <= DRAIN;
                out_valid <= 1'b1;
                out_data  <= pend[0] ? hold[0] : '0;
                out_stale <= ~pend[0];
                out_ch    <= '0;
                out_last  <= (NUM_MIC == 1);
            end else if (last_xfer) begin
                out_valid <= 1'b0;
                state     <= IDLE;
            end else if (xfer) begin
                idx       <= nidx;
                out_data  <= mask[nidx] ? snap[nidx] : '0;
                out_stale <= ~mask[nidx];
                out_ch    <= nidx;
                out_last  <= (nidx == CH_W'(NUM_MIC - 1));
            end
        end
    end

endmodule
